input_cmd_arbiter: RTL and testbench



---
 rtl/cmd_pkg.sv | 78 +++++++
 rtl/input_cmd_arbiter_if.sv | 47 ++++
 rtl/cmd_fifo.sv | 58 +++++
 rtl/input_cmd_arbiter.sv | 148 ++++++++++++++
 tb/tb_input_cmd_arbiter.sv | 371 +++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/cmd_pkg.sv
// Command codes, scan-code constants and shared types for the input command arbiter.
// The scan-code lookup lives here so the decoder and any checker agree on one map.
package cmd_pkg;

    typedef enum logic [2:0] {
        CMD_NONE   = 3'd0,
        CMD_UP     = 3'd1,
        CMD_LEFT   = 3'd2,
        CMD_DOWN   = 3'd3,
        CMD_RIGHT  = 3'd4,
        CMD_DROP   = 3'd5,
        CMD_PAUSE  = 3'd6,
        CMD_ROTATE = 3'd7
    } cmd_e;

    localparam logic [7:0] SC_EXT   = 8'hE0;
    localparam logic [7:0] SC_BRK   = 8'hF0;
    localparam logic [7:0] SC_W     = 8'h1D;
    localparam logic [7:0] SC_A     = 8'h1C;
    localparam logic [7:0] SC_S     = 8'h1B;
    localparam logic [7:0] SC_D     = 8'h23;
    localparam logic [7:0] SC_SPACE = 8'h29;
    localparam logic [7:0] SC_ESC   = 8'h76;
    localparam logic [7:0] SC_UP    = 8'h75;
    localparam logic [7:0] SC_LEFT  = 8'h6B;
    localparam logic [7:0] SC_DOWN  = 8'h72;
    localparam logic [7:0] SC_RIGHT = 8'h74;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_EXT     = 2'd1,
        S_BRK     = 2'd2,
        S_EXT_BRK = 2'd3
    } kb_state_e;

    typedef struct packed {
        cmd_e cmd;
        logic brk;
    } cmd_evt_t;

    typedef struct packed {
        cmd_evt_t evt;
        logic     vld;
    } slot_t;

    localparam int NUM_SLOTS = 4;
    localparam int SLOT_KB   = 0;
    localparam int SLOT_B0   = 1;
    localparam int SLOT_B1   = 2;
    localparam int SLOT_B2   = 3;

    // Prefix bytes (E0/F0) never map, so a stray prefix decodes to CMD_NONE.
    function automatic cmd_e sc_to_cmd(input logic [7:0] code, input logic ext);
        cmd_e c;
        c = CMD_NONE;
        if (ext) begin
            case (code)
                SC_UP:    c = CMD_UP;
                SC_LEFT:  c = CMD_LEFT;
                SC_DOWN:  c = CMD_DOWN;
                SC_RIGHT: c = CMD_RIGHT;
                default:  c = CMD_NONE;
            endcase
        end else begin
            case (code)
                SC_W:     c = CMD_UP;
                SC_A:     c = CMD_LEFT;
                SC_S:     c = CMD_DOWN;
                SC_D:     c = CMD_RIGHT;
                SC_SPACE: c = CMD_DROP;
                SC_ESC:   c = CMD_PAUSE;
                default:  c = CMD_NONE;
            endcase
        end
        return c;
    endfunction

endpackage

// File: rtl/input_cmd_arbiter_if.sv
// Bundle of the keyboard/button inputs and the command-stream handshake.
// Command handshake: a transfer happens on a clock edge where o_cmd_valid && i_cmd_ready; head data holds while valid && !ready.
interface input_cmd_arbiter_if #(
    parameter int FIFO_DEPTH = 4
);
    import cmd_pkg::*;

    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

    logic [7:0]       i_kb_data;
    logic             i_kb_valid;
    logic [2:0]       i_btn;
    cmd_e             o_cmd;
    logic             o_cmd_break;
    logic             o_cmd_valid;
    logic             i_cmd_ready;
    logic [CNT_W-1:0] o_fifo_count;
    logic             o_overflow;
    kb_state_e        o_dbg_state;

    modport slave (
        input  i_kb_data,
        input  i_kb_valid,
        input  i_btn,
        input  i_cmd_ready,
        output o_cmd,
        output o_cmd_break,
        output o_cmd_valid,
        output o_fifo_count,
        output o_overflow,
        output o_dbg_state
    );

    modport master (
        output i_kb_data,
        output i_kb_valid,
        output i_btn,
        output i_cmd_ready,
        input  o_cmd,
        input  o_cmd_break,
        input  o_cmd_valid,
        input  o_fifo_count,
        input  o_overflow,
        input  o_dbg_state
    );

endinterface

// File: rtl/cmd_fifo.sv
// Synchronous FIFO with power-of-two depth; a push while full is accepted only
// when a pop happens in the same cycle, so the count then stays at DEPTH.
module cmd_fifo #(
    parameter  int DEPTH = 4,
    parameter  int WIDTH = 4,
    localparam int AW    = $clog2(DEPTH),
    localparam int CW    = AW + 1
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             push_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] data_o,
    output logic [CW-1:0]    count_o,
    output logic             full_o,
    output logic             empty_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_q, wr_d;
    logic [AW-1:0]    rd_q, rd_d;
    logic [CW-1:0]    count_q, count_d;
    logic             do_push, do_pop;

    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == CW'(DEPTH));
    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full_o || do_pop);

    always_comb begin
        wr_d    = wr_q;
        rd_d    = rd_q;
        count_d = count_q;
        if (do_push) wr_d = wr_q + 1'b1;
        if (do_pop)  rd_d = rd_q + 1'b1;
        if (do_push && !do_pop)      count_d = count_q + 1'b1;
        else if (!do_push && do_pop) count_d = count_q - 1'b1;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
            wr_q    <= '0;
            rd_q    <= '0;
            count_q <= '0;
        end else begin
            if (do_push) mem_q[wr_q] <= data_i;
            wr_q    <= wr_d;
            rd_q    <= rd_d;
            count_q <= count_d;
        end
    end

    assign data_o  = mem_q[rd_q];
    assign count_o = count_q;

endmodule

// File: rtl/input_cmd_arbiter.sv
// Merges PS/2 scan codes and button pulses into one ordered command stream:
// decoder FSM -> one-deep pending slots -> round-robin grant -> command FIFO.
module input_cmd_arbiter
    import cmd_pkg::*;
#(
    parameter int FIFO_DEPTH = 4
) (
    input logic                 i_clk,
    input logic                 i_rst_n,
    input_cmd_arbiter_if.slave  cmd_if
);

    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

    kb_state_e  kb_state_q, kb_state_d;
    logic       kb_emit;
    cmd_evt_t   kb_evt;

    slot_t      slot_q [NUM_SLOTS];
    slot_t      slot_d [NUM_SLOTS];
    logic [NUM_SLOTS-1:0] new_vld;
    cmd_evt_t   new_evt [NUM_SLOTS];
    logic       drop;

    logic [1:0] rr_q, rr_d;
    logic [1:0] gnt_idx, scan_idx;
    logic       gnt_vld;
    logic       overflow_q;

    logic       pop, can_accept;
    logic       fifo_full, fifo_empty;
    logic [CNT_W-1:0] fifo_count;
    cmd_evt_t   fifo_head;

    // Unmapped codes decode to CMD_NONE and are swallowed without an event.
    always_comb begin
        kb_state_d = kb_state_q;
        kb_evt     = '{cmd: CMD_NONE, brk: 1'b0};
        kb_emit    = 1'b0;
        if (cmd_if.i_kb_valid) begin
            case (kb_state_q)
                S_IDLE: begin
                    if (cmd_if.i_kb_data == SC_EXT)      kb_state_d = S_EXT;
                    else if (cmd_if.i_kb_data == SC_BRK) kb_state_d = S_BRK;
                    else kb_evt.cmd = sc_to_cmd(cmd_if.i_kb_data, 1'b0);
                end
                S_EXT: begin
                    if (cmd_if.i_kb_data == SC_BRK) begin
                        kb_state_d = S_EXT_BRK;
                    end else begin
                        kb_state_d = S_IDLE;
                        kb_evt.cmd = sc_to_cmd(cmd_if.i_kb_data, 1'b1);
                    end
                end
                S_BRK: begin
                    kb_state_d = S_IDLE;
                    kb_evt     = '{cmd: sc_to_cmd(cmd_if.i_kb_data, 1'b0), brk: 1'b1};
                end
                S_EXT_BRK: begin
                    kb_state_d = S_IDLE;
                    kb_evt     = '{cmd: sc_to_cmd(cmd_if.i_kb_data, 1'b1), brk: 1'b1};
                end
                default: kb_state_d = S_IDLE;
            endcase
            kb_emit = (kb_evt.cmd != CMD_NONE);
        end
    end

    always_comb begin
        new_vld[SLOT_KB]  = kb_emit;
        new_evt[SLOT_KB]  = kb_evt;
        new_vld[SLOT_B0]  = cmd_if.i_btn[0];
        new_evt[SLOT_B0]  = '{cmd: CMD_RIGHT, brk: 1'b0};
        new_vld[SLOT_B1]  = cmd_if.i_btn[1];
        new_evt[SLOT_B1]  = '{cmd: CMD_LEFT, brk: 1'b0};
        new_vld[SLOT_B2]  = cmd_if.i_btn[2];
        new_evt[SLOT_B2]  = '{cmd: CMD_ROTATE, brk: 1'b0};
    end

    assign pop        = !fifo_empty && cmd_if.i_cmd_ready;
    assign can_accept = !fifo_full || pop;

    // Scan starts at the round-robin pointer; the first occupied slot wins.
    always_comb begin
        gnt_vld  = 1'b0;
        gnt_idx  = rr_q;
        scan_idx = rr_q;
        for (int k = 0; k < NUM_SLOTS; k++) begin
            scan_idx = rr_q + 2'(k);
            if (!gnt_vld && slot_q[scan_idx].vld) begin
                gnt_vld = 1'b1;
                gnt_idx = scan_idx;
            end
        end
        gnt_vld = gnt_vld && can_accept;
        rr_d    = gnt_vld ? gnt_idx + 2'd1 : rr_q;
    end

    // A slot vacated by this cycle's grant may be refilled by this cycle's event.
    always_comb begin
        drop = 1'b0;
        for (int s = 0; s < NUM_SLOTS; s++) begin
            slot_d[s] = slot_q[s];
            if (gnt_vld && gnt_idx == 2'(s)) slot_d[s].vld = 1'b0;
            if (new_vld[s]) begin
                if (slot_d[s].vld) drop = 1'b1;
                else               slot_d[s] = '{evt: new_evt[s], vld: 1'b1};
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            kb_state_q <= S_IDLE;
            rr_q       <= '0;
            overflow_q <= 1'b0;
            for (int s = 0; s < NUM_SLOTS; s++) slot_q[s] <= '0;
        end else begin
            kb_state_q <= kb_state_d;
            rr_q       <= rr_d;
            overflow_q <= overflow_q | drop;
            for (int s = 0; s < NUM_SLOTS; s++) slot_q[s] <= slot_d[s];
        end
    end

    cmd_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH ($bits(cmd_evt_t))
    ) u_fifo (
        .clk_i   (i_clk),
        .rst_ni  (i_rst_n),
        .push_i  (gnt_vld),
        .data_i  (slot_q[gnt_idx].evt),
        .pop_i   (pop),
        .data_o  (fifo_head),
        .count_o (fifo_count),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    assign cmd_if.o_cmd        = fifo_head.cmd;
    assign cmd_if.o_cmd_break  = fifo_head.brk;
    assign cmd_if.o_cmd_valid  = !fifo_empty;
    assign cmd_if.o_fifo_count = fifo_count;
    assign cmd_if.o_overflow   = overflow_q;
    assign cmd_if.o_dbg_state  = kb_state_q;

endmodule

// File: tb/tb_input_cmd_arbiter.sv
// Bench for input_cmd_arbiter: a queue-based reference model checked every cycle,
// a table of scan-code sequences, directed corner sequences and a random phase.
module tb_input_cmd_arbiter;
    import cmd_pkg::*;

    localparam int DEPTH = 4;
    localparam int W     = 4;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;

    input_cmd_arbiter_if #(.FIFO_DEPTH(DEPTH)) bus ();

    input_cmd_arbiter #(.FIFO_DEPTH(DEPTH)) dut (
        .i_clk  (clk),
        .i_rst_n(rst_n),
        .cmd_if (bus)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Reference model: FIFO as a queue of {cmd,brk}, pending slots, rr pointer, prefix bytes.
    logic [W-1:0] exp_q[$];
    logic [3:0]   m_sd[4];
    bit           m_sv[4];
    int           m_rr;
    bit           m_ovf;
    logic [7:0]   m_pfx[$];

    typedef struct {
        logic [7:0] bytes [3];
        int         n;
        bit         ev;
        logic [2:0] c;
        logic       brk;
    } vec_t;
    vec_t vecs[18];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_head(input string name, input logic [2:0] c, input logic b);
        chk(name, {bus.o_cmd_valid, bus.o_cmd, bus.o_cmd_break}, {1'b1, c, b});
    endtask

    function automatic logic [2:0] tb_map(input logic [7:0] b, input bit ext);
        logic [2:0] r;
        r = 3'd0;
        if (ext) begin
            case (b)
                8'h75: r = 3'd1;
                8'h6B: r = 3'd2;
                8'h72: r = 3'd3;
                8'h74: r = 3'd4;
                default: r = 3'd0;
            endcase
        end else begin
            case (b)
                8'h1D: r = 3'd1;
                8'h1C: r = 3'd2;
                8'h1B: r = 3'd3;
                8'h23: r = 3'd4;
                8'h29: r = 3'd5;
                8'h76: r = 3'd6;
                default: r = 3'd0;
            endcase
        end
        return r;
    endfunction

    task automatic model_reset();
        exp_q.delete();
        m_pfx.delete();
        for (int i = 0; i < 4; i++) begin
            m_sv[i] = 1'b0;
            m_sd[i] = '0;
        end
        m_rr  = 0;
        m_ovf = 1'b0;
    endtask

    // Advance the model by one clock using the inputs currently driven.
    task automatic model_step();
        bit         pop, can, ext, brk;
        int         g;
        logic [2:0] c;
        logic [7:0] b;
        bit         nv[4];
        logic [3:0] nev[4];
        pop = (exp_q.size() != 0) && bus.i_cmd_ready;
        can = (exp_q.size() < DEPTH) || pop;
        g = -1;
        for (int k = 0; k < 4; k++) begin
            int s;
            s = (m_rr + k) % 4;
            if (g < 0 && m_sv[s]) g = s;
        end
        if (pop) void'(exp_q.pop_front());
        if (can && g >= 0) begin
            exp_q.push_back(m_sd[g]);
            m_sv[g] = 1'b0;
            m_rr = (g + 1) % 4;
        end
        for (int i = 0; i < 4; i++) begin
            nv[i]  = 1'b0;
            nev[i] = '0;
        end
        if (bus.i_kb_valid) begin
            b = bus.i_kb_data;
            if (m_pfx.size() == 0 && (b == 8'hE0 || b == 8'hF0)) begin
                m_pfx.push_back(b);
            end else if (m_pfx.size() == 1 && m_pfx[0] == 8'hE0 && b == 8'hF0) begin
                m_pfx.push_back(b);
            end else begin
                ext = (m_pfx.size() > 0) && (m_pfx[0] == 8'hE0);
                brk = (m_pfx.size() > 0) && (m_pfx[m_pfx.size()-1] == 8'hF0);
                c = tb_map(b, ext);
                m_pfx.delete();
                if (c != 3'd0) begin
                    nv[0]  = 1'b1;
                    nev[0] = {c, brk};
                end
            end
        end
        nv[1] = bus.i_btn[0]; nev[1] = {3'd4, 1'b0};
        nv[2] = bus.i_btn[1]; nev[2] = {3'd2, 1'b0};
        nv[3] = bus.i_btn[2]; nev[3] = {3'd7, 1'b0};
        for (int s = 0; s < 4; s++) begin
            if (nv[s]) begin
                if (m_sv[s]) m_ovf = 1'b1;
                else begin
                    m_sv[s] = 1'b1;
                    m_sd[s] = nev[s];
                end
            end
        end
    endtask

    task automatic check_outputs();
        chk("count", bus.o_fifo_count, exp_q.size());
        chk("valid", bus.o_cmd_valid, exp_q.size() != 0);
        chk("overflow", bus.o_overflow, m_ovf);
        if (exp_q.size() != 0) chk("head", {bus.o_cmd, bus.o_cmd_break}, exp_q[0]);
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
        check_outputs();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic send_kb(input logic [7:0] b);
        bus.i_kb_valid = 1'b1;
        bus.i_kb_data  = b;
        tick();
        bus.i_kb_valid = 1'b0;
        bus.i_kb_data  = 8'h00;
    endtask

    task automatic pulse_btn(input logic [2:0] m);
        bus.i_btn = m;
        tick();
        bus.i_btn = 3'b000;
    endtask

    task automatic do_reset();
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        chk("rst_valid", bus.o_cmd_valid, 1'b0);
        chk("rst_count", bus.o_fifo_count, 0);
        chk("rst_cmd", bus.o_cmd, 3'd0);
        chk("rst_brk", bus.o_cmd_break, 1'b0);
        chk("rst_ovf", bus.o_overflow, 1'b0);
        chk("rst_state", bus.o_dbg_state, S_IDLE);
        repeat (2) @(posedge clk);
        #1;
        chk("rst_hold_valid", bus.o_cmd_valid, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic add_vec(input int i, input logic [7:0] b0, input logic [7:0] b1,
                           input logic [7:0] b2, input int n, input bit ev,
                           input logic [2:0] c, input logic brk);
        vecs[i].bytes[0] = b0;
        vecs[i].bytes[1] = b1;
        vecs[i].bytes[2] = b2;
        vecs[i].n   = n;
        vecs[i].ev  = ev;
        vecs[i].c   = c;
        vecs[i].brk = brk;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] t5_send[5];
        logic [2:0] t5_head[5];
        logic [7:0] pool[12];
        int pops;

        add_vec(0,  8'h1D, 8'h00, 8'h00, 1, 1, 3'd1, 1'b0);
        add_vec(1,  8'hF0, 8'h1D, 8'h00, 2, 1, 3'd1, 1'b1);
        add_vec(2,  8'hE0, 8'h6B, 8'h00, 2, 1, 3'd2, 1'b0);
        add_vec(3,  8'hE0, 8'hF0, 8'h6B, 3, 1, 3'd2, 1'b1);
        add_vec(4,  8'hE0, 8'h75, 8'h00, 2, 1, 3'd1, 1'b0);
        add_vec(5,  8'hE0, 8'hF0, 8'h72, 3, 1, 3'd3, 1'b1);
        add_vec(6,  8'hE0, 8'h74, 8'h00, 2, 1, 3'd4, 1'b0);
        add_vec(7,  8'h29, 8'h00, 8'h00, 1, 1, 3'd5, 1'b0);
        add_vec(8,  8'hF0, 8'h76, 8'h00, 2, 1, 3'd6, 1'b1);
        add_vec(9,  8'h1B, 8'h00, 8'h00, 1, 1, 3'd3, 1'b0);
        add_vec(10, 8'h23, 8'h00, 8'h00, 1, 1, 3'd4, 1'b0);
        add_vec(11, 8'hE0, 8'hE0, 8'h00, 2, 0, 3'd0, 1'b0);
        add_vec(12, 8'h1C, 8'h00, 8'h00, 1, 1, 3'd2, 1'b0);
        add_vec(13, 8'hE0, 8'h1D, 8'h00, 2, 0, 3'd0, 1'b0);
        add_vec(14, 8'hF0, 8'h55, 8'h00, 2, 0, 3'd0, 1'b0);
        add_vec(15, 8'h55, 8'h00, 8'h00, 1, 0, 3'd0, 1'b0);
        add_vec(16, 8'hF0, 8'hF0, 8'h00, 2, 0, 3'd0, 1'b0);
        add_vec(17, 8'h1C, 8'h00, 8'h00, 1, 1, 3'd2, 1'b0);

        bus.i_kb_data   = 8'h00;
        bus.i_kb_valid  = 1'b0;
        bus.i_btn       = 3'b000;
        bus.i_cmd_ready = 1'b0;
        do_reset();

        // Make then break of the same key, with exact two-cycle latency.
        bus.i_cmd_ready = 1'b1;
        send_kb(8'h1D);
        chk("t1_lat1_valid", bus.o_cmd_valid, 1'b0);
        tick();
        chk_head("t1_up_make", 3'd1, 1'b0);
        send_kb(8'hF0);
        send_kb(8'h1D);
        tick();
        chk_head("t1_up_break", 3'd1, 1'b1);
        tick();
        chk("t1_drained", bus.o_fifo_count, 0);

        // Scan-code table.
        bus.i_cmd_ready = 1'b0;
        for (int i = 0; i < 18; i++) begin
            for (int j = 0; j < vecs[i].n; j++) send_kb(vecs[i].bytes[j]);
            idle(2);
            if (vecs[i].ev) chk_head("vec_head", vecs[i].c, vecs[i].brk);
            else            chk("vec_none", bus.o_fifo_count, 0);
            bus.i_cmd_ready = 1'b1;
            idle(1);
            bus.i_cmd_ready = 1'b0;
            chk("vec_empty", bus.o_fifo_count, 0);
        end
        chk("vec_no_ovf", bus.o_overflow, 1'b0);

        // All four sources in one cycle, round-robin from KB.
        do_reset();
        bus.i_cmd_ready = 1'b1;
        bus.i_btn       = 3'b111;
        bus.i_kb_valid  = 1'b1;
        bus.i_kb_data   = 8'h29;
        tick();
        bus.i_btn       = 3'b000;
        bus.i_kb_valid  = 1'b0;
        bus.i_kb_data   = 8'h00;
        tick();
        chk_head("t3_drop", 3'd5, 1'b0);
        tick();
        chk_head("t3_right", 3'd4, 1'b0);
        tick();
        chk_head("t3_left", 3'd2, 1'b0);
        tick();
        chk_head("t3_rotate", 3'd7, 1'b0);
        chk("t3_no_ovf", bus.o_overflow, 1'b0);
        tick();
        chk("t3_drained", bus.o_fifo_count, 0);

        // Back-pressure overflow on B0.
        bus.i_cmd_ready = 1'b0;
        for (int i = 0; i < 6; i++) pulse_btn(3'b001);
        idle(2);
        chk("t4_count_full", bus.o_fifo_count, DEPTH);
        chk("t4_ovf_set", bus.o_overflow, 1'b1);
        bus.i_cmd_ready = 1'b1;
        pops = 0;
        for (int i = 0; i < 12; i++) begin
            if (bus.o_cmd_valid) begin
                pops++;
                chk_head("t4_drain_head", 3'd4, 1'b0);
            end
            tick();
        end
        chk("t4_pops", pops, 5);
        chk("t4_ovf_sticky", bus.o_overflow, 1'b1);

        // Full FIFO with simultaneous push and pop across pointer wrap.
        do_reset();
        bus.i_cmd_ready = 1'b0;
        send_kb(8'h1D);
        send_kb(8'h1C);
        send_kb(8'h1B);
        send_kb(8'h23);
        send_kb(8'h29);
        idle(2);
        chk("t5_full", bus.o_fifo_count, DEPTH);
        t5_send = '{8'h76, 8'h1D, 8'h1C, 8'h1B, 8'h23};
        t5_head = '{3'd2, 3'd3, 3'd4, 3'd5, 3'd6};
        for (int i = 0; i < 5; i++) begin
            bus.i_cmd_ready = 1'b1;
            tick();
            bus.i_cmd_ready = 1'b0;
            chk("t5_count_hold", bus.o_fifo_count, DEPTH);
            chk_head("t5_head", t5_head[i], 1'b0);
            send_kb(t5_send[i]);
            tick();
        end

        // Reset right after a break prefix discards it.
        send_kb(8'hF0);
        chk("t6_state_brk", bus.o_dbg_state, S_BRK);
        do_reset();
        bus.i_cmd_ready = 1'b1;
        send_kb(8'h1C);
        tick();
        chk_head("t6_left_make", 3'd2, 1'b0);
        tick();

        // Random traffic against the model.
        do_reset();
        pool = '{8'hE0, 8'hF0, 8'h1D, 8'h1C, 8'h1B, 8'h23,
                 8'h29, 8'h76, 8'h75, 8'h6B, 8'h72, 8'h74};
        for (int i = 0; i < 600; i++) begin
            int sel;
            bus.i_kb_valid = ($urandom_range(0, 2) == 0);
            sel = $urandom_range(0, 13);
            bus.i_kb_data = (sel < 12) ? pool[sel] : 8'($urandom_range(0, 255));
            bus.i_btn[0] = ($urandom_range(0, 5) == 0);
            bus.i_btn[1] = ($urandom_range(0, 5) == 0);
            bus.i_btn[2] = ($urandom_range(0, 5) == 0);
            bus.i_cmd_ready = ($urandom_range(0, 3) != 0);
            tick();
        end
        bus.i_kb_valid  = 1'b0;
        bus.i_kb_data   = 8'h00;
        bus.i_btn       = 3'b000;
        bus.i_cmd_ready = 1'b1;
        idle(12);
        chk("rand_drained", bus.o_fifo_count, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
